dcache_req_arb: RTL and testbench

Shares the single HPDcache core request port among NrReq data-side requesters (index 0 = PTW, 1 = load unit, 2 = store/AMO unit), allocating a cache transaction ID per accepted request and routing each response back to its originator with its original local ID. Sits between the load/store/MMU units and the HPDcache inside the cache subsystem wrapper. Also reports outstanding-transaction status for fence/flush sequencing.

---
 rtl/dcache_arb_pkg.sv | 48 ++++
 rtl/dcache_rr_arb_lock.sv | 96 +++++++++
 rtl/dcache_req_arb.sv | 198 +++++++++++++++++++
 tb/tb_dcache_req_arb.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_arb_pkg.sv
// ----------------------------------------------------------------------------
// dcache_arb_pkg
// Shared types and constants for the data-cache request arbiter.
//   - Default configuration: requester count, ID, address and data widths.
//   - SRC_W: width of a requester index (clog2 of the requester count).
//   - trk_entry_t: one transaction tracker slot {valid, src, local tid}.
//   - req_payload_t / rsp_payload_t: muxed request payload and registered
//     response bundle.
//   - src_onehot(): requester index to one-hot response strobe.
// The struct widths follow the package defaults. The top-level parameters
// default to these values and must not be overridden independently.
// ----------------------------------------------------------------------------
package dcache_arb_pkg;

  localparam int unsigned NR_REQ = 3;
  localparam int unsigned ID_W   = 3;
  localparam int unsigned ADDR_W = 64;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned BE_W   = DATA_W / 8;
  localparam int unsigned SRC_W  = (NR_REQ > 1) ? $clog2(NR_REQ) : 1;

  typedef struct packed {
    logic             valid;
    logic [SRC_W-1:0] src;
    logic [ID_W-1:0]  tid;
  } trk_entry_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              we;
    logic [DATA_W-1:0] wdata;
    logic [BE_W-1:0]   be;
    logic [ID_W-1:0]   tid;
  } req_payload_t;

  typedef struct packed {
    logic [NR_REQ-1:0] valid;
    logic [ID_W-1:0]   tid;
    logic [DATA_W-1:0] rdata;
    logic              error;
  } rsp_payload_t;

  // Requester index to one-hot strobe vector.
  function automatic logic [NR_REQ-1:0] src_onehot(input logic [SRC_W-1:0] src);
    src_onehot = {{(NR_REQ-1){1'b0}}, 1'b1} << src;
  endfunction

endpackage

// File: rtl/dcache_rr_arb_lock.sv
// ----------------------------------------------------------------------------
// dcache_rr_arb_lock
// Round-robin arbiter that holds its winner while the downstream port stalls.
// It also has an optional fixed-priority override for requester 0.
// Ports:
//   clk_i, rst_i  clock, asynchronous active-high reset
//   req_i         request vector
//   prio_i        1 = requester 0 wins whenever it requests (lock still honoured)
//   stall_i       request presented but not accepted this cycle -> lock next cycle
//   advance_i     handshake this cycle -> move pointer past the winner
//   gnt_o         one-hot grant (zero when no request)
//   idx_o         index of the granted requester
//   locked_o      grant is currently forced by a previous stall
// ----------------------------------------------------------------------------
module dcache_rr_arb_lock
  import dcache_arb_pkg::*;
#(
  parameter int unsigned N    = NR_REQ,
  parameter int unsigned IdxW = SRC_W
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [N-1:0]    req_i,
  input  logic            prio_i,
  input  logic            stall_i,
  input  logic            advance_i,
  output logic [N-1:0]    gnt_o,
  output logic [IdxW-1:0] idx_o,
  output logic            locked_o
);

  logic [IdxW-1:0] r_ptr;
  logic [IdxW-1:0] r_lock_idx;
  logic            r_lock;
  logic [IdxW-1:0] w_rr_idx;
  logic            w_rr_found;
  logic [IdxW-1:0] w_win_idx;
  logic            w_locked;

  // Round-robin search starting at the pointer.
  always_comb begin
    logic [IdxW-1:0] v_idx;
    w_rr_idx   = '0;
    w_rr_found = 1'b0;
    v_idx      = '0;
    for (int unsigned k = 0; k < N; k++) begin
      v_idx = IdxW'((32'(r_ptr) + k) % N);
      if (!w_rr_found && req_i[v_idx]) begin
        w_rr_found = 1'b1;
        w_rr_idx   = v_idx;
      end else begin
        w_rr_found = w_rr_found;
      end
    end
  end

  // Winner selection: a held stall beats priority, priority beats round-robin.
  always_comb begin
    w_locked = r_lock & req_i[r_lock_idx];
    if (w_locked) begin
      w_win_idx = r_lock_idx;
    end else if (prio_i && req_i[0]) begin
      w_win_idx = '0;
    end else begin
      w_win_idx = w_rr_idx;
    end
  end

  // Grant vector and status outputs.
  always_comb begin
    idx_o    = w_win_idx;
    locked_o = w_locked;
    if (|req_i) begin
      gnt_o = {{(N-1){1'b0}}, 1'b1} << w_win_idx;
    end else begin
      gnt_o = '0;
    end
  end

  // Pointer and stall-lock state.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_ptr      <= '0;
      r_lock     <= 1'b0;
      r_lock_idx <= '0;
    end else begin
      r_lock     <= stall_i;
      r_lock_idx <= w_win_idx;
      // Priority grants to requester 0 leave the rotation untouched.
      if (advance_i && !(prio_i && (w_win_idx == '0))) begin
        r_ptr <= (w_win_idx == IdxW'(N - 1)) ? '0 : (w_win_idx + IdxW'(1));
      end
    end
  end

endmodule

// File: rtl/dcache_req_arb.sv
// ----------------------------------------------------------------------------
// dcache_req_arb
// Shares one HPDcache core request port among NrReq data-side requesters
// (0 = PTW, 1 = load, 2 = store/AMO). Each accepted request gets a cache
// transaction ID, which is the index of the lowest free tracker entry.
// Responses are routed back one cycle later with the requester's own ID.
// Optional feature macro: DCACHE_ARB_PTW_PRIO_EN. When it is defined,
// requester 0 takes priority over round-robin.
// Ports:
//   clk_i, rst_i                 clock, asynchronous active-high reset
//   req_*_i / req_ready_o        per-requester request channel
//   cache_req_*_o / _ready_i     muxed request to the cache (combinational)
//   cache_rsp_*_i                cache response (no backpressure)
//   rsp_valid_o                  one-hot registered response strobe
//   rsp_tid_o/_rdata_o/_error_o  shared registered response bus
//   busy_o                       any tracker entry allocated
//   unexp_rsp_o                  pulse: response hit an unallocated entry
// ----------------------------------------------------------------------------
module dcache_req_arb
  import dcache_arb_pkg::*;
#(
  parameter int unsigned NrReq     = NR_REQ,
  parameter int unsigned IdWidth   = ID_W,
  parameter int unsigned AddrWidth = ADDR_W,
  parameter int unsigned DataWidth = DATA_W
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [NrReq-1:0]               req_valid_i,
  output logic [NrReq-1:0]               req_ready_o,
  input  logic [NrReq*AddrWidth-1:0]     req_addr_i,
  input  logic [NrReq-1:0]               req_we_i,
  input  logic [NrReq*DataWidth-1:0]     req_wdata_i,
  input  logic [NrReq*DataWidth/8-1:0]   req_be_i,
  input  logic [NrReq*IdWidth-1:0]       req_tid_i,
  output logic                           cache_req_valid_o,
  input  logic                           cache_req_ready_i,
  output logic [AddrWidth-1:0]           cache_req_addr_o,
  output logic                           cache_req_we_o,
  output logic [DataWidth-1:0]           cache_req_wdata_o,
  output logic [DataWidth/8-1:0]         cache_req_be_o,
  output logic [IdWidth-1:0]             cache_req_tid_o,
  input  logic                           cache_rsp_valid_i,
  input  logic [IdWidth-1:0]             cache_rsp_tid_i,
  input  logic [DataWidth-1:0]           cache_rsp_rdata_i,
  input  logic                           cache_rsp_error_i,
  output logic [NrReq-1:0]               rsp_valid_o,
  output logic [IdWidth-1:0]             rsp_tid_o,
  output logic [DataWidth-1:0]           rsp_rdata_o,
  output logic                           rsp_error_o,
  output logic                           busy_o,
  output logic                           unexp_rsp_o
);

  localparam int unsigned BeW    = DataWidth / 8;
  localparam int unsigned NumEnt = 2 ** IdWidth;

  trk_entry_t          r_trk [NumEnt];
  logic [IdWidth-1:0]  r_lock_tid;
  rsp_payload_t        r_rsp;
  logic                r_unexp;

  logic [NumEnt-1:0]   w_valid_vec;
  logic                w_full;
  logic [IdWidth-1:0]  w_free_idx;
  logic [IdWidth-1:0]  w_alloc_tid;
  logic [NrReq-1:0]    w_gnt;
  logic [SRC_W-1:0]    w_win;
  logic                w_locked;
  logic                w_prio;
  logic                w_cvalid;
  logic                w_hs;
  logic                w_stall;
  logic [IdWidth-1:0]  w_win_ltid;
  req_payload_t        w_req_pl;
  trk_entry_t          w_rsp_ent;
  logic                w_rsp_hit;

`ifdef DCACHE_ARB_PTW_PRIO_EN
  assign w_prio = 1'b1;
`else
  assign w_prio = 1'b0;
`endif

  // Tracker occupancy and lowest free entry (registered state only, so an
  // entry freed this cycle is not reused until the next one).
  always_comb begin
    w_free_idx = '0;
    for (int i = 0; i < int'(NumEnt); i++) begin
      w_valid_vec[i] = r_trk[i].valid;
    end
    for (int i = int'(NumEnt) - 1; i >= 0; i--) begin
      if (!r_trk[i].valid) begin
        w_free_idx = IdWidth'(i);
      end else begin
        w_free_idx = w_free_idx;
      end
    end
  end

  assign w_full = &w_valid_vec;
  assign busy_o = |w_valid_vec;

  dcache_rr_arb_lock #(
    .N    (NrReq),
    .IdxW (SRC_W)
  ) u_rr_arb (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .req_i     (req_valid_i),
    .prio_i    (w_prio),
    .stall_i   (w_stall),
    .advance_i (w_hs),
    .gnt_o     (w_gnt),
    .idx_o     (w_win),
    .locked_o  (w_locked)
  );

  // Request-side handshake. Outputs are forced low while reset is asserted.
  always_comb begin
    w_cvalid = (|req_valid_i) & ~w_full & ~rst_i;
    w_hs     = w_cvalid & cache_req_ready_i;
    w_stall  = w_cvalid & ~cache_req_ready_i;
    // A stalled request keeps the tid it was first presented with.
    w_alloc_tid = w_locked ? r_lock_tid : w_free_idx;
    if (cache_req_ready_i && !w_full && !rst_i) begin
      req_ready_o = w_gnt;
    end else begin
      req_ready_o = '0;
    end
  end

  // Payload mux from the granted requester.
  always_comb begin
    w_win_ltid     = req_tid_i[w_win*IdWidth +: IdWidth];
    w_req_pl.addr  = req_addr_i[w_win*AddrWidth +: AddrWidth];
    w_req_pl.we    = req_we_i[w_win];
    w_req_pl.wdata = req_wdata_i[w_win*DataWidth +: DataWidth];
    w_req_pl.be    = req_be_i[w_win*BeW +: BeW];
    w_req_pl.tid   = w_alloc_tid;
  end

  assign cache_req_valid_o = w_cvalid;
  assign cache_req_addr_o  = w_req_pl.addr;
  assign cache_req_we_o    = w_req_pl.we;
  assign cache_req_wdata_o = w_req_pl.wdata;
  assign cache_req_be_o    = w_req_pl.be;
  assign cache_req_tid_o   = w_req_pl.tid;

  assign w_rsp_ent = r_trk[cache_rsp_tid_i];
  assign w_rsp_hit = cache_rsp_valid_i & w_rsp_ent.valid;

  // Tracker: allocate on handshake, release on a matching response. The two
  // never touch the same entry because allocation only picks free slots.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(NumEnt); i++) begin
        r_trk[i] <= '0;
      end
      r_lock_tid <= '0;
    end else begin
      if (w_hs) begin
        r_trk[w_alloc_tid] <= '{valid: 1'b1, src: w_win, tid: w_win_ltid};
      end
      if (w_rsp_hit) begin
        r_trk[cache_rsp_tid_i].valid <= 1'b0;
      end
      if (w_stall) begin
        r_lock_tid <= w_alloc_tid;
      end
    end
  end

  // Registered response routing and unexpected-response flag.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rsp   <= '0;
      r_unexp <= 1'b0;
    end else begin
      r_unexp <= cache_rsp_valid_i & ~w_rsp_ent.valid;
      if (w_rsp_hit) begin
        r_rsp.valid <= src_onehot(w_rsp_ent.src);
        r_rsp.tid   <= w_rsp_ent.tid;
        r_rsp.rdata <= cache_rsp_rdata_i;
        r_rsp.error <= cache_rsp_error_i;
      end else begin
        r_rsp.valid <= '0;
      end
    end
  end

  assign rsp_valid_o = r_rsp.valid;
  assign rsp_tid_o   = r_rsp.tid;
  assign rsp_rdata_o = r_rsp.rdata;
  assign rsp_error_o = r_rsp.error;
  assign unexp_rsp_o = r_unexp;

endmodule

// File: tb/tb_dcache_req_arb.sv
// ----------------------------------------------------------------------------
// tb_dcache_req_arb
// Self-checking bench for dcache_req_arb. Requesters hold each request until
// it is accepted, and a cache model returns responses in random order.
// A reference model predicts the request side every cycle. Expected
// responses go into a scoreboard that a separate monitor drains.
// Honours DCACHE_ARB_PTW_PRIO_EN the same way as the design.
// ----------------------------------------------------------------------------
module tb_dcache_req_arb;

  localparam int N  = 3;
  localparam int IW = 3;
  localparam int AW = 64;
  localparam int DW = 64;
  localparam int BW = DW / 8;
  localparam int NE = 8;
`ifdef DCACHE_ARB_PTW_PRIO_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      req_valid_i;
  logic [N-1:0]      req_ready_o;
  logic [N*AW-1:0]   req_addr_i;
  logic [N-1:0]      req_we_i;
  logic [N*DW-1:0]   req_wdata_i;
  logic [N*BW-1:0]   req_be_i;
  logic [N*IW-1:0]   req_tid_i;
  logic              cache_req_valid_o;
  logic              cache_req_ready_i;
  logic [AW-1:0]     cache_req_addr_o;
  logic              cache_req_we_o;
  logic [DW-1:0]     cache_req_wdata_o;
  logic [BW-1:0]     cache_req_be_o;
  logic [IW-1:0]     cache_req_tid_o;
  logic              cache_rsp_valid_i;
  logic [IW-1:0]     cache_rsp_tid_i;
  logic [DW-1:0]     cache_rsp_rdata_i;
  logic              cache_rsp_error_i;
  logic [N-1:0]      rsp_valid_o;
  logic [IW-1:0]     rsp_tid_o;
  logic [DW-1:0]     rsp_rdata_o;
  logic              rsp_error_o;
  logic              busy_o;
  logic              unexp_rsp_o;

  always #5 clk = ~clk;

  dcache_req_arb dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_addr_i(req_addr_i), .req_we_i(req_we_i), .req_wdata_i(req_wdata_i),
    .req_be_i(req_be_i), .req_tid_i(req_tid_i),
    .cache_req_valid_o(cache_req_valid_o), .cache_req_ready_i(cache_req_ready_i),
    .cache_req_addr_o(cache_req_addr_o), .cache_req_we_o(cache_req_we_o),
    .cache_req_wdata_o(cache_req_wdata_o), .cache_req_be_o(cache_req_be_o),
    .cache_req_tid_o(cache_req_tid_o),
    .cache_rsp_valid_i(cache_rsp_valid_i), .cache_rsp_tid_i(cache_rsp_tid_i),
    .cache_rsp_rdata_i(cache_rsp_rdata_i), .cache_rsp_error_i(cache_rsp_error_i),
    .rsp_valid_o(rsp_valid_o), .rsp_tid_o(rsp_tid_o), .rsp_rdata_o(rsp_rdata_o),
    .rsp_error_o(rsp_error_o), .busy_o(busy_o), .unexp_rsp_o(unexp_rsp_o)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard of expected response-side events
  typedef struct {
    int           due;
    bit           unexp;
    logic [N-1:0] oh;
    logic [IW-1:0] tid;
    logic [DW-1:0] rdata;
    logic         err;
  } sb_item_t;
  sb_item_t sb[$];

  // Reference model: tracker contents, rotation order, stall hold
  bit            m_v   [NE];
  int            m_src [NE];
  logic [IW-1:0] m_tid [NE];
  int            rr_next;
  int            lock_src;
  logic [IW-1:0] lock_tid;

  // Requesters and cache model
  bit            pend    [N];
  logic [AW-1:0] p_addr  [N];
  logic          p_we    [N];
  logic [DW-1:0] p_wdata [N];
  logic [BW-1:0] p_be    [N];
  logic [IW-1:0] p_tid   [N];
  int            outst[$];
  int            p_req, p_rdy, p_rsp;
  bit            force_rsp;
  logic [IW-1:0] force_tid;

  task automatic model_clear();
    for (int e = 0; e < NE; e++) m_v[e] = 1'b0;
    rr_next  = 0;
    lock_src = -1;
    lock_tid = '0;
  endtask

  task automatic drop_outst(input int t);
    for (int j = 0; j < outst.size(); j++) begin
      if (outst[j] == t) begin
        outst.delete(j);
        break;
      end
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (!pend[i] && ($urandom_range(0, 99) < p_req)) begin
        pend[i]    = 1'b1;
        p_addr[i]  = {$urandom, $urandom};
        p_we[i]    = $urandom_range(0, 1) == 1;
        p_wdata[i] = {$urandom, $urandom};
        p_be[i]    = 8'($urandom);
        p_tid[i]   = 3'($urandom);
      end
      req_valid_i[i]           = pend[i];
      req_addr_i[i*AW +: AW]   = p_addr[i];
      req_we_i[i]              = p_we[i];
      req_wdata_i[i*DW +: DW]  = p_wdata[i];
      req_be_i[i*BW +: BW]     = p_be[i];
      req_tid_i[i*IW +: IW]    = p_tid[i];
    end
    cache_req_ready_i = $urandom_range(0, 99) < p_rdy;
    cache_rsp_valid_i = 1'b0;
    cache_rsp_tid_i   = '0;
    cache_rsp_rdata_i = '0;
    cache_rsp_error_i = 1'b0;
    if (force_rsp) begin
      cache_rsp_valid_i = 1'b1;
      cache_rsp_tid_i   = force_tid;
      cache_rsp_rdata_i = 64'hDEAD_BEEF;
      drop_outst(int'(force_tid));
    end else if ($urandom_range(0, 99) < p_rsp) begin
      int t;
      if (outst.size() > 0 && $urandom_range(0, 9) != 0) begin
        t = outst[$urandom_range(0, outst.size() - 1)];
      end else begin
        t = $urandom_range(0, NE - 1);
      end
      drop_outst(t);
      cache_rsp_valid_i = 1'b1;
      cache_rsp_tid_i   = IW'(t);
      cache_rsp_rdata_i = {$urandom, $urandom};
      cache_rsp_error_i = $urandom_range(0, 7) == 0;
    end
  endtask

  // Predict this cycle's request side, then commit what the coming edge does.
  task automatic check_update();
    bit full, busy, any, locked, exp_valid, hs;
    int win, free_i;
    logic [IW-1:0] exp_tid;
    logic [N-1:0]  exp_rdy;
    full = 1'b1; busy = 1'b0; free_i = -1; any = 1'b0; win = -1;
    for (int e = 0; e < NE; e++) begin
      if (m_v[e]) busy = 1'b1;
      else begin
        full = 1'b0;
        if (free_i < 0) free_i = e;
      end
    end
    for (int i = 0; i < N; i++) any |= pend[i];
    locked = (lock_src >= 0) && pend[lock_src];
    if (locked) win = lock_src;
    else if (PRIO && pend[0]) win = 0;
    else begin
      for (int k = 0; k < N; k++) begin
        if (win < 0 && pend[(rr_next + k) % N]) win = (rr_next + k) % N;
      end
    end
    exp_tid   = locked ? lock_tid : IW'((free_i < 0) ? 0 : free_i);
    exp_valid = any && !full;
    hs        = exp_valid && cache_req_ready_i;
    exp_rdy   = hs ? (N'(1) << win) : '0;

    chk("cache_req_valid", 64'(cache_req_valid_o), 64'(exp_valid));
    chk("req_ready", 64'(req_ready_o), 64'(exp_rdy));
    chk("busy", 64'(busy_o), 64'(busy));
    if (exp_valid) begin
      chk("cache_req_tid", 64'(cache_req_tid_o), 64'(exp_tid));
      chk("cache_req_addr", cache_req_addr_o, p_addr[win]);
      chk("cache_req_we", 64'(cache_req_we_o), 64'(p_we[win]));
      chk("cache_req_wdata", cache_req_wdata_o, p_wdata[win]);
      chk("cache_req_be", 64'(cache_req_be_o), 64'(p_be[win]));
    end

    if (cache_rsp_valid_i) begin
      sb_item_t it;
      int t;
      t = int'(cache_rsp_tid_i);
      it.due = cyc + 1;
      it.unexp = !m_v[t];
      it.oh = m_v[t] ? (N'(1) << m_src[t]) : '0;
      it.tid = m_tid[t];
      it.rdata = cache_rsp_rdata_i;
      it.err = cache_rsp_error_i;
      sb.push_back(it);
      m_v[t] = 1'b0;
    end
    if (hs) begin
      m_v[exp_tid]   = 1'b1;
      m_src[exp_tid] = win;
      m_tid[exp_tid] = p_tid[win];
      pend[win]      = 1'b0;
      outst.push_back(int'(exp_tid));
      if (!(PRIO && win == 0)) rr_next = (win + 1) % N;
    end
    if (exp_valid && !cache_req_ready_i) begin
      lock_src = win;
      lock_tid = exp_tid;
    end else begin
      lock_src = -1;
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
    drive();
    @(negedge clk);
    check_update();
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    for (int i = 0; i < N; i++) pend[i] = 1'b0;
    req_valid_i       = '0;
    cache_req_ready_i = 1'b0;
    cache_rsp_valid_i = 1'b0;
    #1;
    chk("rst_cache_req_valid", 64'(cache_req_valid_o), 64'd0);
    chk("rst_req_ready", 64'(req_ready_o), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid_o), 64'd0);
    chk("rst_rsp_tid", 64'(rsp_tid_o), 64'd0);
    chk("rst_rsp_rdata", rsp_rdata_o, 64'd0);
    chk("rst_rsp_error", 64'(rsp_error_o), 64'd0);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_unexp", 64'(unexp_rsp_o), 64'd0);
    model_clear();
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Monitor: compare response-side outputs against the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (sb.size() > 0 && sb[0].due == cyc) begin
          sb_item_t it;
          it = sb.pop_front();
          chk("rsp_valid", 64'(rsp_valid_o), 64'(it.oh));
          chk("unexp_rsp", 64'(unexp_rsp_o), 64'(it.unexp));
          if (!it.unexp) begin
            chk("rsp_tid", 64'(rsp_tid_o), 64'(it.tid));
            chk("rsp_rdata", rsp_rdata_o, it.rdata);
            chk("rsp_error", 64'(rsp_error_o), 64'(it.err));
          end
        end else begin
          chk("rsp_idle", 64'({rsp_valid_o, unexp_rsp_o}), 64'd0);
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    req_valid_i = '0; req_addr_i = '0; req_we_i = '0; req_wdata_i = '0;
    req_be_i = '0; req_tid_i = '0; cache_req_ready_i = 1'b0;
    cache_rsp_valid_i = 1'b0; cache_rsp_tid_i = '0; cache_rsp_rdata_i = '0;
    cache_rsp_error_i = 1'b0; force_rsp = 1'b0; force_tid = '0;
    for (int i = 0; i < N; i++) pend[i] = 1'b0;
    model_clear();
    do_reset();

    // Everyone requesting, cache always ready, no responses: fill to full.
    p_req = 100; p_rdy = 100; p_rsp = 0;
    repeat (11) step();
    // Free entry 5, which must be the next tid handed out.
    force_rsp = 1'b1; force_tid = 3'd5;
    step();
    force_rsp = 1'b0;
    repeat (3) step();

    // Mixed traffic, then heavy stalls.
    p_req = 40; p_rdy = 70; p_rsp = 35;
    repeat (1500) step();
    p_rdy = 20; p_rsp = 30;
    repeat (500) step();

    // Reset with transactions in flight; their later responses are unexpected.
    p_req = 80; p_rdy = 90; p_rsp = 10;
    repeat (20) step();
    do_reset();
    p_req = 40; p_rdy = 70; p_rsp = 60;
    repeat (500) step();

    // Drain.
    p_req = 0; p_rsp = 80;
    repeat (100) step();
    p_rsp = 0;
    repeat (2) step();
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
